dlx_memsys: RTL and testbench
=============================

Name: dlx_memsys

Overview:
- Memory responder for the DLX pipeline top level. Serves the instruction port (pc -> instruction word) and the data port (mem_addr / memdata_out / mem_en -> memdata_in) that the pipeline drives as initiator.
- Owns a program-load front end. An external host streams instruction words in with a valid/ready handshake while the block holds the pipeline in reset, then releases it.
- Sits beside dlxpipeline in the system top level. Its outputs connect directly to the pipeline's inst_in, memdata_in and reset.

Parameters:
- IMEM_AW, 8, instruction memory word-address width (depth 2^IMEM_AW words).
- DMEM_AW, 8, data memory word-address width (depth 2^DMEM_AW words).
- NOP_INST, 32'h00000000, instruction word returned for out-of-range pc.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  byte address of instruction fetch from pipeline.
- inst_out  out  32  instruction word to pipeline inst_in.
- mem_addr  in  32  data byte address from pipeline.
- mem_wdata  in  32  store data from pipeline (its memdata_out).
- mem_en  in  1  store enable from pipeline.
- mem_rdata  out  32  load data to pipeline (its memdata_in).
- load_valid  in  1  host has a program word on load_data.
- load_data  in  32  program word.
- load_last  in  1  qualifies the final program word.
- load_ready  out  1  block accepts a load word this cycle.
- cpu_reset  out  1  reset to pipeline, active-high.
- load_done  out  1  program loaded, pipeline running.
- load_ovf  out  1  sticky: load words were dropped because imem was full.
- addr_err  out  1  one-cycle pulse: illegal store was suppressed.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- FSM states: LOAD, RUN (plus CLEAR when the optional feature is enabled).
  - Reset -> LOAD (CLEAR with the macro).
  - In LOAD, a handshake (load_valid && load_ready) with load_last=1 -> RUN.
  - RUN holds until reset.
- Reset values:
  - state=LOAD; load_cnt=0; cpu_reset=1; load_ovf=0; addr_err=0.
  - load_ready=0 and load_done=0 while reset is high.
  - Memory arrays are not cleared by reset (except under the macro).
- load_ready = (state==LOAD) && !reset, combinational.
- Load handshake:
  - On each accepted word: imem[load_cnt] <= load_data; load_cnt++.
  - If load_cnt has reached 2^IMEM_AW: the word is dropped, load_ovf <= 1, load_cnt saturates.
  - load_last is still honoured after overflow.
- cpu_reset:
  - Registered. Stays 1 through LOAD and the edge that enters RUN.
  - Drops to 0 on the next edge, giving one full RUN cycle before the pipeline starts.
- load_done = (state==RUN), registered state decode.
- Instruction read:
  - Combinational, zero latency: inst_out = imem[pc[IMEM_AW+1:2]] if pc[31:IMEM_AW+2]==0, else NOP_INST.
  - pc[1:0] is ignored.
  - In LOAD, inst_out = NOP_INST.
- Data read:
  - Combinational: mem_rdata = dmem[mem_addr[DMEM_AW+1:2]] if in range, else 32'h0.
  - mem_addr[1:0] is ignored for reads.
- Data write:
  - On an edge with state==RUN && mem_en, the word is written only if mem_addr[1:0]==0 and mem_addr[31:DMEM_AW+2]==0.
  - Otherwise the write is suppressed and addr_err pulses high on the following cycle.
  - mem_en is ignored outside RUN, with no error.
- Read-during-write to the same word: mem_rdata shows the old data until the edge, the new data after.
- Reset mid-load: returns to LOAD with load_cnt=0. Already-written imem words remain until overwritten.
- Reset in RUN: cpu_reset reasserts on the same edge, and the load must be repeated.

Optional Feature:
- Macro: DLX_MEM_CLEAR_EN.
- With the macro:
  - Reset enters CLEAR. A clr_idx counter writes 0 to dmem[clr_idx] and writes NOP_INST to imem[clr_idx] (when in range), one word per cycle.
  - When clr_idx reaches max(2^IMEM_AW, 2^DMEM_AW)-1 the FSM goes to LOAD.
  - load_ready=0 and cpu_reset=1 throughout CLEAR.
  - Reset during CLEAR restarts clr_idx at 0.
- Without the macro: there is no CLEAR state, reset goes straight to LOAD, and memory contents are undefined until written.

Test Plan:
- Load sequence:
  - Stimulus: reset 2 cycles, then push 4 words 0x20010005, 0x20020003, 0x00221820, 0xAC030010 with load_last on the 4th.
  - Required: load_ready=1 throughout; load_done=1 the cycle after the 4th handshake; cpu_reset falls exactly one cycle later.
  - Then pc=0/4/8/12 returns those words, and pc=0x1000 returns NOP_INST.
- Store/load:
  - Stimulus in RUN: mem_en=1, mem_addr=0x10, mem_wdata=0xDEADBEEF.
  - Required: mem_rdata at 0x10 = 0xDEADBEEF on the next cycle, and 0x0 before the edge (macro build).
- Illegal stores:
  - Stimulus: mem_addr=0x12 (misaligned), then mem_addr=0x400 (out of range, DMEM_AW=8).
  - Required: no dmem change; addr_err pulses one cycle after each; mem_rdata(0x400)=0.
- Overflow:
  - Stimulus: IMEM_AW=2, push 6 words with last on the 6th.
  - Required: words 0-3 stored; load_ovf=1 after the 5th handshake; FSM enters RUN.
- Reset mid-load:
  - Stimulus: 2 words, reset 1 cycle, then 1 word with load_last.
  - Required: new word at pc=0, old 2nd word still at pc=4, cpu_reset falls as in the load sequence test.
- Clear (macro build):
  - Required: load_ready stays low for 256 cycles after reset; then dmem reads 0 at every word and imem returns NOP_INST.

Source files
------------

// File: rtl/dlx_memsys.sv
// dlx_memsys: instruction/data memory responder for the DLX pipeline, with a
// program-load front end that holds the pipeline in reset while a host streams
// instruction words in, then releases it.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   pc / inst_out           instruction fetch (byte address in, word out, comb.)
//   mem_addr / mem_wdata    data access from the pipeline
//   mem_en / mem_rdata      store enable, load data (comb.)
//   load_valid / load_data  host program stream (valid/ready handshake)
//   load_last / load_ready  final-word qualifier, accept indication
//   cpu_reset               reset to the pipeline, active-high
//   load_done               program loaded, pipeline running
//   load_ovf                sticky: load words dropped because imem was full
//   addr_err                one-cycle pulse after a suppressed illegal store
//
// Optional feature: define DLX_MEM_CLEAR_EN to add a CLEAR state after reset
// that writes NOP_INST to every imem word and 0 to every dmem word.

module dlx_memsys #(
    parameter int unsigned IMEM_AW  = 8,
    parameter int unsigned DMEM_AW  = 8,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] inst_out,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_en,
    output logic [31:0] mem_rdata,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_ovf,
    output logic        addr_err
);

    localparam int unsigned IMEM_DEPTH = 2 ** IMEM_AW;
    localparam int unsigned DMEM_DEPTH = 2 ** DMEM_AW;

`ifdef DLX_MEM_CLEAR_EN
    typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_CLEAR} state_t;
    localparam state_t RESET_STATE = ST_CLEAR;
    localparam int unsigned CLR_AW = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;
`else
    typedef enum logic [0:0] {ST_LOAD, ST_RUN} state_t;
    localparam state_t RESET_STATE = ST_LOAD;
`endif

    state_t state;
    state_t state_next;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];

    // One extra bit so the counter can sit at IMEM_DEPTH once imem is full.
    logic [IMEM_AW:0] load_cnt;
    logic             load_full;
    logic             accept;
    logic             store_req;
    logic             store_ok;
    logic             pc_in_range;
    logic             daddr_in_range;
    logic             unused_bits;

`ifdef DLX_MEM_CLEAR_EN
    logic [CLR_AW-1:0] clr_idx;
    logic              clr_done;
    logic              clr_in_imem;
    logic              clr_in_dmem;
`endif

    assign load_full      = load_cnt[IMEM_AW];
    assign load_ready     = (state == ST_LOAD) && !reset;
    assign load_done      = (state == ST_RUN) && !reset;
    assign accept         = load_valid && load_ready;

    assign pc_in_range    = (pc >> (IMEM_AW + 2)) == 32'd0;
    assign daddr_in_range = (mem_addr >> (DMEM_AW + 2)) == 32'd0;

    assign store_req      = (state == ST_RUN) && mem_en && !reset;
    assign store_ok       = store_req && (mem_addr[1:0] == 2'b00) && daddr_in_range;

    assign inst_out  = ((state == ST_RUN) && pc_in_range) ? imem[pc[IMEM_AW+1:2]] : NOP_INST;
    assign mem_rdata = daddr_in_range ? dmem[mem_addr[DMEM_AW+1:2]] : 32'h0;

    assign unused_bits = ^pc[1:0];

`ifdef DLX_MEM_CLEAR_EN
    assign clr_done    = (clr_idx == '1);
    assign clr_in_imem = (clr_idx >> IMEM_AW) == '0;
    assign clr_in_dmem = (clr_idx >> DMEM_AW) == '0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: begin
                if (accept && load_last) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
`ifdef DLX_MEM_CLEAR_EN
            ST_CLEAR: begin
                if (clr_done) begin
                    state_next = ST_LOAD;
                end
            end
`endif
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RESET_STATE;
            load_cnt  <= '0;
            cpu_reset <= 1'b1;
            load_ovf  <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            state     <= state_next;
            // Sampling the current state delays the release by one edge after
            // entering RUN, so the pipeline sees one full RUN cycle in reset.
            cpu_reset <= (state != ST_RUN);
            addr_err  <= store_req && !store_ok;
            if (accept) begin
                if (load_full) begin
                    load_ovf <= 1'b1;
                end else begin
                    load_cnt <= load_cnt + 1'b1;
                end
            end
        end
    end

`ifdef DLX_MEM_CLEAR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            clr_idx <= '0;
        end else if (state == ST_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
        end
    end
`endif

    // Memory arrays carry no reset; the clear sweep (when built in) is the
    // only path that initialises them.
    always_ff @(posedge clock) begin
        if (accept && !load_full) begin
            imem[load_cnt[IMEM_AW-1:0]] <= load_data;
        end
        if (store_ok) begin
            dmem[mem_addr[DMEM_AW+1:2]] <= mem_wdata;
        end
`ifdef DLX_MEM_CLEAR_EN
        if (state == ST_CLEAR) begin
            if (clr_in_imem) begin
                imem[clr_idx[IMEM_AW-1:0]] <= NOP_INST;
            end
            if (clr_in_dmem) begin
                dmem[clr_idx[DMEM_AW-1:0]] <= 32'h0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_dlx_memsys.sv
// tb_dlx_memsys: self-checking bench for dlx_memsys (IMEM_AW=2, DMEM_AW=8).
// Expected values come from a word-level model of the memories and load flow.
// Builds with or without DLX_MEM_CLEAR_EN.

module tb_dlx_memsys;

    localparam int unsigned IAW    = 2;
    localparam int unsigned DAW    = 8;
    localparam int unsigned IDEPTH = 4;
    localparam int unsigned DDEPTH = 256;
    localparam logic [31:0] NOP    = 32'hA5A5_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] inst_out;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_en;
    logic [31:0] mem_rdata;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        cpu_reset;
    logic        load_done;
    logic        load_ovf;
    logic        addr_err;

    dlx_memsys #(
        .IMEM_AW (IAW),
        .DMEM_AW (DAW),
        .NOP_INST(NOP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pc        (pc),
        .inst_out  (inst_out),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_en    (mem_en),
        .mem_rdata (mem_rdata),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_last (load_last),
        .load_ready(load_ready),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .load_ovf  (load_ovf),
        .addr_err  (addr_err)
    );

    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model
    logic [31:0] im_m [IDEPTH];
    bit          im_v [IDEPTH];
    logic [31:0] dm_m [DDEPTH];
    bit          dm_v [DDEPTH];
    int unsigned ld_cnt;
    bit          running;
    bit          ovf_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit exp_inst(input logic [31:0] p, output logic [31:0] e);
        if (!running || p >= 4 * IDEPTH) begin
            e = NOP;
            return 1'b1;
        end
        e = im_m[p / 4];
        return im_v[p / 4];
    endfunction

    function automatic bit exp_rd(input logic [31:0] a, output logic [31:0] e);
        if (a >= 4 * DDEPTH) begin
            e = 32'h0;
            return 1'b1;
        end
        e = dm_m[a / 4];
        return dm_v[a / 4];
    endfunction

    task automatic model_reset();
        ld_cnt  = 0;
        running = 1'b0;
        ovf_m   = 1'b0;
`ifdef DLX_MEM_CLEAR_EN
        for (int i = 0; i < IDEPTH; i++) begin
            im_m[i] = NOP;
            im_v[i] = 1'b1;
        end
        for (int i = 0; i < DDEPTH; i++) begin
            dm_m[i] = 32'h0;
            dm_v[i] = 1'b1;
        end
`endif
    endtask

    task automatic check_inst(input logic [31:0] p);
        logic [31:0] e;
        pc = p;
        @(negedge clock);
        if (exp_inst(p, e)) chk("inst_out", inst_out, e);
    endtask

    task automatic check_rd(input logic [31:0] a);
        logic [31:0] e;
        mem_addr = a;
        @(negedge clock);
        if (exp_rd(a, e)) chk("mem_rdata", mem_rdata, e);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        #1;
        while (load_ready !== 1'b1 && n < 600) begin
            chk("cpu_reset_while_not_ready", cpu_reset, 1'b1);
            tick();
            n++;
        end
        chk("load_ready_rise", load_ready, 1'b1);
`ifdef DLX_MEM_CLEAR_EN
        chk("clear_cycles", n, 256);
`else
        chk("ready_cycles", n, 0);
`endif
        chk("load_done_in_load", load_done, 1'b0);
        chk("cpu_reset_in_load", cpu_reset, 1'b1);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        chk("load_ready_in_reset", load_ready, 1'b0);
        chk("load_done_in_reset", load_done, 1'b0);
        repeat (cycles) tick();
        chk("cpu_reset_after_reset", cpu_reset, 1'b1);
        chk("load_ovf_after_reset", load_ovf, 1'b0);
        chk("addr_err_after_reset", addr_err, 1'b0);
        chk("load_ready_in_reset2", load_ready, 1'b0);
        reset = 1'b0;
        model_reset();
        wait_ready();
    endtask

    task automatic push(input logic [31:0] d, input bit last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        #1;
        chk("load_ready", load_ready, 1'b1);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (ld_cnt < IDEPTH) begin
            im_m[ld_cnt] = d;
            im_v[ld_cnt] = 1'b1;
            ld_cnt++;
        end else begin
            ovf_m = 1'b1;
        end
        if (last) running = 1'b1;
        chk("load_ovf", load_ovf, ovf_m);
        chk("load_done", load_done, running);
        chk("cpu_reset_during_load", cpu_reset, 1'b1);
    endtask

    // One clock with the given store request; checks read data around the edge
    // and the addr_err pulse that follows it.
    task automatic do_store(input logic [31:0] a, input logic [31:0] w, input bit en);
        logic [31:0] e;
        bit legal;
        mem_addr  = a;
        mem_wdata = w;
        mem_en    = en;
        #1;
        if (exp_rd(a, e)) chk("rdata_before_edge", mem_rdata, e);
        if (exp_inst(pc, e)) chk("inst_out_run", inst_out, e);
        tick();
        legal = (a % 4 == 0) && (a < 4 * DDEPTH);
        chk("addr_err", addr_err, running && en && !legal);
        if (running && en && legal) begin
            dm_m[a / 4] = w;
            dm_v[a / 4] = 1'b1;
        end
        if (exp_rd(a, e)) chk("rdata_after_edge", mem_rdata, e);
        mem_en = 1'b0;
    endtask

    logic [31:0] a;
    int unsigned kind;

    initial begin
        reset      = 1'b1;
        pc         = 32'h0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_en     = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'h0;
        load_last  = 1'b0;
        model_reset();

        // Initial reset and load sequence
        do_reset(2);
        check_inst(32'h0);
`ifdef DLX_MEM_CLEAR_EN
        for (int i = 0; i < DDEPTH; i++) check_rd(32'(i) * 4);
`endif
        push(32'h2001_0005, 1'b0);
        push(32'h2002_0003, 1'b0);
        push(32'h0022_1820, 1'b0);
        push(32'hAC03_0010, 1'b1);
        tick();
        chk("cpu_reset_release", cpu_reset, 1'b0);
        chk("load_done_run", load_done, 1'b1);
        check_inst(32'h0);
        check_inst(32'h5);
        check_inst(32'hA);
        check_inst(32'hF);
        check_inst(32'h1000);
        check_inst(32'h10);

        // Directed stores: legal, misaligned, out of range
        do_store(32'h0, 32'h0BAD_F00D, 1'b1);
        do_store(32'h10, 32'hDEAD_BEEF, 1'b1);
        do_store(32'h12, 32'h1234_5678, 1'b1);
        do_store(32'h12, 32'h0, 1'b0);
        do_store(32'h400, 32'hFFFF_FFFF, 1'b1);
        do_store(32'h0, 32'h0, 1'b0);
        check_rd(32'h10);

        // Randomised traffic in RUN
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6)      a = 32'($urandom_range(0, 15)) * 4;
            else if (kind < 8) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            else if (kind < 9) a = 32'h400 + 32'($urandom_range(0, 255)) * 4;
            else               a = $urandom | 32'h8000_0000;
            pc = 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
            do_store(a, $urandom, 1'($urandom_range(0, 1)));
        end

        // Overflow with a 4-word imem
        do_reset(1);
        for (int i = 0; i < 6; i++) push(32'h1111_0000 + 32'(i), i == 5);
        tick();
        chk("cpu_reset_release_ovf", cpu_reset, 1'b0);
        chk("load_ovf_sticky", load_ovf, 1'b1);
        for (int i = 0; i < 4; i++) check_inst(32'(i) * 4);

        // Reset mid-load, with stores attempted while loading
        do_reset(1);
        push(32'hCAFE_0001, 1'b0);
        push(32'hCAFE_0002, 1'b0);
        do_store(32'h13, 32'h5555_5555, 1'b1);
        do_store(32'h10, 32'h7777_7777, 1'b1);
        do_reset(1);
        push(32'hBEEF_0003, 1'b1);
        tick();
        chk("cpu_reset_release_mid", cpu_reset, 1'b0);
        for (int i = 0; i < 4; i++) check_inst(32'(i) * 4);
        check_rd(32'h10);
        check_rd(32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
